// File: rtl/yarc_pkg.sv
// Shared types and constants for the core's load/store path.
package yarc_pkg;

    localparam int XLEN_DEFAULT = 32;

    // RV32I funct3 encodings for loads and stores (stores use B/H/W only).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } lsu_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       mem_to_reg;
        logic       ins_valid;
    } wb_ctrl_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge port between the LSU (master) and memory (slave).
interface mem_stage_lsu_if #(
    parameter int XLEN = yarc_pkg::XLEN_DEFAULT
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane replication, load lane select and extension.
module lsu_align
    import yarc_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path can infer a latch.
        ld_byte = rdata[7:0];
        case (addr_lo)
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            2'd3:    ld_byte = rdata[31:24];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        load_data  = rdata;
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = (funct3 == F3_B) ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the req/ack data port, stalls upstream, fills MEM/WB.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and set mem_wb_misaligned.
module mem_stage_lsu
    import yarc_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_mem_memread,
    input  logic             ex_mem_memwrite,
    input  logic             ex_mem_mem_to_reg,
    input  logic             ex_mem_regwrite,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_ins_valid,
    input  logic [2:0]       ex_mem_funct3,
    input  logic [XLEN-1:0]  ex_mem_addr,
    input  logic [XLEN-1:0]  ex_mem_wdata,
    mem_stage_lsu_if.master  dmem,
    output logic             mem_stall,
    output logic [4:0]       mem_wb_rd,
    output logic             mem_wb_regwrite,
    output logic             mem_wb_mem_to_reg,
    output logic             mem_wb_ins_valid,
    output logic [XLEN-1:0]  mem_wb_load_data
`ifdef MISALIGN_TRAP_EN
   ,output logic             mem_wb_misaligned
`endif
);
    lsu_state_t      state_q, state_d;
    wb_ctrl_t        wb_q, lat_ctrl_q, ex_ctrl;
    logic [2:0]      lat_funct3_q;
    logic [1:0]      lat_off_q;
    logic            access, issue, wb_regwrite;
    logic [2:0]      al_funct3;
    logic [1:0]      al_off;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata, al_load;

    assign access = ex_mem_ins_valid & (ex_mem_memread | ex_mem_memwrite);

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = access &
                        (((ex_mem_funct3[1:0] == 2'b01) & ex_mem_addr[0]) |
                         ((ex_mem_funct3[1:0] == 2'b10) & (ex_mem_addr[1:0] != 2'b00)));
    assign issue       = access & ~misaligned;
    assign wb_regwrite = ex_mem_regwrite & ~misaligned;
`else
    assign issue       = access;
    assign wb_regwrite = ex_mem_regwrite;
`endif

    assign ex_ctrl = '{rd: ex_mem_rd, regwrite: wb_regwrite,
                       mem_to_reg: ex_mem_mem_to_reg, ins_valid: ex_mem_ins_valid};

    // One aligner serves both directions: store lanes while idle, load extraction while pending.
    assign al_funct3 = (state_q == REQ) ? lat_funct3_q : ex_mem_funct3;
    assign al_off    = (state_q == REQ) ? lat_off_q    : ex_mem_addr[1:0];

    lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_off),
        .wdata      (ex_mem_wdata),
        .rdata      (dmem.rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .load_data  (al_load)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue)    state_d = REQ;
            REQ:     if (dmem.ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            IDLE:    mem_stall = issue;
            REQ:     mem_stall = ~dmem.ack;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem.req         <= 1'b0;
            dmem.we          <= 1'b0;
            dmem.addr        <= '0;
            dmem.be          <= '0;
            dmem.wdata       <= '0;
            lat_ctrl_q       <= '0;
            lat_funct3_q     <= '0;
            lat_off_q        <= '0;
            wb_q             <= '0;
            mem_wb_load_data <= '0;
        end else begin
            mem_wb_load_data <= '0;
            wb_q             <= '0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        dmem.req     <= 1'b1;
                        dmem.we      <= ex_mem_memwrite;
                        dmem.addr    <= {ex_mem_addr[XLEN-1:2], 2'b00};
                        dmem.be      <= al_be;
                        dmem.wdata   <= al_wdata;
                        lat_ctrl_q   <= ex_ctrl;
                        lat_funct3_q <= ex_mem_funct3;
                        lat_off_q    <= ex_mem_addr[1:0];
                    end else begin
                        wb_q <= ex_ctrl;
                    end
                end
                REQ: begin
                    if (dmem.ack) begin
                        dmem.req         <= 1'b0;
                        wb_q             <= lat_ctrl_q;
                        mem_wb_load_data <= dmem.we ? '0 : al_load;
                    end
                end
                default: dmem.req <= 1'b0;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_wb_misaligned <= 1'b0;
        else      mem_wb_misaligned <= (state_q == IDLE) & misaligned;
    end
`endif

    assign mem_wb_rd         = wb_q.rd;
    assign mem_wb_regwrite   = wb_q.regwrite;
    assign mem_wb_mem_to_reg = wb_q.mem_to_reg;
    assign mem_wb_ins_valid  = wb_q.ins_valid;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, reset corner case, random traffic.
// Build with MISALIGN_TRAP_EN defined to exercise the misalignment trap variant.
module tb_mem_stage_lsu;
    import yarc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_memread, ex_mem_memwrite, ex_mem_mem_to_reg, ex_mem_regwrite;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_ins_valid;
    logic [2:0]  ex_mem_funct3;
    logic [31:0] ex_mem_addr, ex_mem_wdata;
    logic        mem_stall;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_regwrite, mem_wb_mem_to_reg, mem_wb_ins_valid;
    logic [31:0] mem_wb_load_data;
`ifdef MISALIGN_TRAP_EN
    logic        mem_wb_misaligned;
`endif

    always #5 clk = ~clk;

    mem_stage_lsu_if dmem_bus ();

    mem_stage_lsu dut (
        .clk               (clk),
        .rst               (rst),
        .ex_mem_memread    (ex_mem_memread),
        .ex_mem_memwrite   (ex_mem_memwrite),
        .ex_mem_mem_to_reg (ex_mem_mem_to_reg),
        .ex_mem_regwrite   (ex_mem_regwrite),
        .ex_mem_rd         (ex_mem_rd),
        .ex_mem_ins_valid  (ex_mem_ins_valid),
        .ex_mem_funct3     (ex_mem_funct3),
        .ex_mem_addr       (ex_mem_addr),
        .ex_mem_wdata      (ex_mem_wdata),
        .dmem              (dmem_bus),
        .mem_stall         (mem_stall),
        .mem_wb_rd         (mem_wb_rd),
        .mem_wb_regwrite   (mem_wb_regwrite),
        .mem_wb_mem_to_reg (mem_wb_mem_to_reg),
        .mem_wb_ins_valid  (mem_wb_ins_valid),
        .mem_wb_load_data  (mem_wb_load_data)
`ifdef MISALIGN_TRAP_EN
       ,.mem_wb_misaligned (mem_wb_misaligned)
`endif
    );

    typedef struct {
        logic        memread, memwrite, mem_to_reg, regwrite, ins_valid;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] addr, wdata, rdata;
        int          dly;
        logic        stray;
        logic        exp_access, exp_mis, exp_we, exp_regwrite;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_load;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Reference: sizes, lanes and extension computed from plain arithmetic on the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          nbytes, lane;
        logic [31:0] mask, val;
        logic        acc, mis;
        r      = v;
        nbytes = (v.funct3[1:0] == 2'b00) ? 1 : (v.funct3[1:0] == 2'b01) ? 2 : 4;
        lane   = (nbytes == 1) ? int'(v.addr[1:0]) : (nbytes == 2) ? int'(v.addr[1]) * 2 : 0;
        acc    = v.ins_valid && (v.memread || v.memwrite);
        mis    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis    = acc && ((nbytes == 2 && v.addr[0]) || (nbytes == 4 && v.addr[1:0] != 2'b00));
`endif
        r.exp_access   = acc && !mis;
        r.exp_mis      = mis;
        r.exp_we       = v.memwrite;
        r.exp_regwrite = v.regwrite && !mis;
        r.exp_be       = 4'(((1 << nbytes) - 1) << lane);
        r.exp_wdata    = (nbytes == 1) ? {24'h0, v.wdata[7:0]} * 32'h0101_0101 :
                         (nbytes == 2) ? {16'h0, v.wdata[15:0]} * 32'h0001_0001 : v.wdata;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
        val  = (v.rdata >> (8 * lane)) & mask;
        if (!v.funct3[2] && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        r.exp_load = (r.exp_access && !v.memwrite) ? val : 32'h0;
        return r;
    endfunction

    function automatic vec_t mem_row(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] rdata, input int dly);
        vec_t v;
        v = '{memread: ld, memwrite: st, mem_to_reg: ld & ~st, regwrite: ld & ~st, ins_valid: 1'b1,
              rd: 5'd10, funct3: f3, addr: addr, wdata: wdata, rdata: rdata, dly: dly, stray: 1'b0,
              exp_access: 1'b1, exp_mis: 1'b0, exp_we: st, exp_regwrite: ld & ~st,
              exp_be: 4'h0, exp_wdata: 32'h0, exp_load: 32'h0};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ex_mem_memread    = v.memread;
        ex_mem_memwrite   = v.memwrite;
        ex_mem_mem_to_reg = v.mem_to_reg;
        ex_mem_regwrite   = v.regwrite;
        ex_mem_rd         = v.rd;
        ex_mem_ins_valid  = v.ins_valid;
        ex_mem_funct3     = v.funct3;
        ex_mem_addr       = v.addr;
        ex_mem_wdata      = v.wdata;
    endtask

    task automatic check_wb(input string tag, input vec_t v);
        check({tag, "_wb_rd"},   32'(mem_wb_rd),         32'(v.rd));
        check({tag, "_wb_rw"},   32'(mem_wb_regwrite),   32'(v.exp_regwrite));
        check({tag, "_wb_m2r"},  32'(mem_wb_mem_to_reg), 32'(v.mem_to_reg));
        check({tag, "_wb_iv"},   32'(mem_wb_ins_valid),  32'(v.ins_valid));
        check({tag, "_wb_load"}, mem_wb_load_data,       v.exp_load);
`ifdef MISALIGN_TRAP_EN
        check({tag, "_wb_mis"},  32'(mem_wb_misaligned), 32'(v.exp_mis));
`endif
    endtask

    // Entered and left 1 time unit after a rising edge; plays upstream stage and memory.
    task automatic apply(input string tag, input vec_t v);
        drive(v);
        dmem_bus.ack   = v.exp_access ? 1'b0 : v.stray;
        dmem_bus.rdata = v.rdata;
        @(negedge clk);
        check({tag, "_stall0"}, 32'(mem_stall), 32'(v.exp_access));
        @(posedge clk); #1;
        dmem_bus.ack = 1'b0;
        if (!v.exp_access) begin
            check({tag, "_noreq"}, 32'(dmem_bus.req), 32'd0);
            check_wb(tag, v);
        end else begin
            check({tag, "_req"},   32'(dmem_bus.req),  32'd1);
            check({tag, "_we"},    32'(dmem_bus.we),   32'(v.exp_we));
            check({tag, "_addr"},  dmem_bus.addr,      {v.addr[31:2], 2'b00});
            check({tag, "_be"},    32'(dmem_bus.be),   32'(v.exp_be));
            check({tag, "_wdata"}, dmem_bus.wdata,     v.exp_wdata);
            check({tag, "_bubble"}, 32'(mem_wb_ins_valid | mem_wb_regwrite), 32'd0);
            for (int k = 0; k < v.dly; k++) begin
                @(negedge clk);
                check({tag, "_stallw"}, 32'(mem_stall), 32'd1);
                @(posedge clk); #1;
                check({tag, "_reqhold"},  32'(dmem_bus.req), 32'd1);
                check({tag, "_addrhold"}, dmem_bus.addr,     {v.addr[31:2], 2'b00});
            end
            dmem_bus.ack = 1'b1;
            @(negedge clk);
            check({tag, "_stallack"}, 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
            dmem_bus.ack = 1'b0;
            check({tag, "_reqdrop"}, 32'(dmem_bus.req), 32'd0);
            check_wb(tag, v);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        st_f3 = '{F3_B, F3_H, F3_W};

        // Directed table: inputs plus hand-derived expectations.
        v = mem_row(1, 0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 3);
        v.exp_be = 4'hF; v.exp_load = 32'hDEADBEEF; tbl.push_back(v);
        v = mem_row(1, 0, F3_B,  32'h103, 32'h0,        32'h80112233, 0);
        v.exp_be = 4'h8; v.exp_load = 32'hFFFFFF80; tbl.push_back(v);
        v = mem_row(1, 0, F3_BU, 32'h103, 32'h0,        32'h80112233, 1);
        v.exp_be = 4'h8; v.exp_load = 32'h00000080; tbl.push_back(v);
        v = mem_row(0, 1, F3_H,  32'h102, 32'h00001234, 32'h0,        2);
        v.exp_be = 4'hC; v.exp_wdata = 32'h12341234; tbl.push_back(v);
        v = mem_row(0, 0, F3_W,  32'h7,   32'h0,        32'h0,        0);
        v.rd = 5'd5; v.regwrite = 1; v.exp_regwrite = 1; v.exp_access = 0; v.stray = 1; tbl.push_back(v);
        v = mem_row(1, 0, F3_H,  32'h102, 32'h0,        32'h80112233, 0);
        v.exp_be = 4'hC; v.exp_load = 32'hFFFF8011; tbl.push_back(v);
        v = mem_row(1, 0, F3_HU, 32'h000, 32'h0,        32'h1234F00D, 1);
        v.exp_be = 4'h3; v.exp_load = 32'h0000F00D; tbl.push_back(v);
        v = mem_row(0, 1, F3_B,  32'h101, 32'h000000A5, 32'h0,        0);
        v.exp_be = 4'h2; v.exp_wdata = 32'hA5A5A5A5; tbl.push_back(v);
        v = mem_row(0, 1, F3_W,  32'h10C, 32'h01234567, 32'h0,        1);
        v.exp_be = 4'hF; v.exp_wdata = 32'h01234567; tbl.push_back(v);
        v = mem_row(1, 1, F3_W,  32'h020, 32'h55AA55AA, 32'hFFFFFFFF, 0);
        v.exp_be = 4'hF; v.exp_wdata = 32'h55AA55AA; tbl.push_back(v);
        v = mem_row(1, 0, F3_W,  32'h040, 32'h0,        32'h0,        0);
        v.ins_valid = 0; v.rd = 5'd9; v.exp_access = 0; v.exp_load = 32'h0; tbl.push_back(v);
        v = mem_row(1, 0, F3_B,  32'h101, 32'h0,        32'h00007F00, 0);
        v.exp_be = 4'h2; v.exp_load = 32'h0000007F; tbl.push_back(v);
        v = mem_row(1, 0, F3_W,  32'h101, 32'h0,        32'hCAFEF00D, 0);
`ifdef MISALIGN_TRAP_EN
        v.exp_access = 0; v.exp_mis = 1; v.exp_regwrite = 0; v.exp_be = 4'h0;
`else
        v.exp_be = 4'hF; v.exp_load = 32'hCAFEF00D;
`endif
        tbl.push_back(v);

        // Reset state.
        rst = 1'b0;
        drive(mem_row(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0));
        ex_mem_ins_valid = 1'b0; ex_mem_rd = 5'd0;
        dmem_bus.ack = 1'b0; dmem_bus.rdata = 32'h0;
        #2;
        check("rst_req",   32'(dmem_bus.req), 32'd0);
        check("rst_we",    32'(dmem_bus.we),  32'd0);
        check("rst_addr",  dmem_bus.addr,     32'd0);
        check("rst_be",    32'(dmem_bus.be),  32'd0);
        check("rst_wdata", dmem_bus.wdata,    32'd0);
        check("rst_stall", 32'(mem_stall),    32'd0);
        check("rst_wb",    {mem_wb_rd, mem_wb_regwrite, mem_wb_mem_to_reg, mem_wb_ins_valid}, 32'd0);
        check("rst_load",  mem_wb_load_data,  32'd0);
`ifdef MISALIGN_TRAP_EN
        check("rst_mis",   32'(mem_wb_misaligned), 32'd0);
`endif
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

        // Reset while a request is pending: req drops at once, the late ack is ignored.
        v = mem_row(1, 0, F3_W, 32'h40, 32'h0, 32'h0, 0);
        v.rd = 5'd3;
        drive(v);
        @(posedge clk); #1;
        check("rreq_issue", 32'(dmem_bus.req), 32'd1);
        #2 rst = 1'b0;
        drive(mem_row(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0));
        ex_mem_ins_valid = 1'b0; ex_mem_rd = 5'd0;
        #1;
        check("rreq_drop",  32'(dmem_bus.req),  32'd0);
        check("rreq_stall", 32'(mem_stall),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'h12345678;
        @(negedge clk);
        check("rreq_ackstall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dmem_bus.ack = 1'b0;
        check("rreq_noreq", 32'(dmem_bus.req), 32'd0);
        check("rreq_wb",    {mem_wb_rd, mem_wb_regwrite, mem_wb_mem_to_reg, mem_wb_ins_valid}, 32'd0);
        check("rreq_load",  mem_wb_load_data,  32'd0);

        // Random traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            v.memread    = (kind == 1) || (kind == 3);
            v.memwrite   = (kind >= 2);
            v.funct3     = v.memwrite ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            v.ins_valid  = ($urandom_range(0, 7) != 0);
            v.regwrite   = 1'($urandom);
            v.mem_to_reg = v.memread;
            v.rd         = 5'($urandom);
            v.addr       = $urandom;
            v.wdata      = $urandom;
            v.rdata      = $urandom;
            v.dly        = int'($urandom_range(0, 3));
            v.stray      = 1'($urandom);
            v = model(v);
            apply($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
